// File: rtl/store_aligner.sv
`default_nettype none
// ============================================================================
// Module   : store_aligner
// Purpose  : Converts a right-aligned store request (address, size, rs2 data)
//            into one or two bus-aligned write beats carrying lane-shifted
//            data, a byte strobe and an expanded bit mask.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/req_ready - request handshake (ready only when idle)
//            req_addr/size/data  - store byte address, size code, rs2 data
//            out_valid/out_ready - beat handshake
//            out_addr/data/strb/mask/last - aligned beat payload
//            err                 - one-cycle pulse when an illegal request
//                                  is presented while idle
// Config   : STORE_ALIGNER_MISALIGN_EN - when defined, a request crossing a
//            bus word is split into two beats; when undefined it is rejected
//            with err and the second-beat state is not built.
// Revision : 1.0 - initial release
// ============================================================================
module store_aligner #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic [DATA_W-1:0]   req_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_strb,
    output logic [DATA_W-1:0]   out_mask,
    output logic                out_last,
    output logic                err
);

    localparam int c_BYTES = DATA_W / 8;
    localparam int c_OFF_W = $clog2(c_BYTES);
`ifdef STORE_ALIGNER_MISALIGN_EN
    localparam int c_SPAN  = 2;
`else
    localparam int c_SPAN  = 1;
`endif
    // The shifted request only needs a second bus word when splitting is on.
    localparam int c_WIDE_B = c_SPAN * c_BYTES;
    localparam int c_WIDE_W = c_SPAN * DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
`ifdef STORE_ALIGNER_MISALIGN_EN
    localparam logic [1:0] S_BEAT1 = 2'd2;
`endif

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_WIDE_W-1:0] r_data;
    logic [c_WIDE_B-1:0] r_strb;
`ifdef STORE_ALIGNER_MISALIGN_EN
    logic                r_cross;
`endif

    logic [c_OFF_W-1:0]  w_off;
    logic [3:0]          w_nbytes;
    logic [4:0]          w_end;
    logic                w_cross;
    logic                w_illegal;
    logic                w_accept;
    logic [c_WIDE_B-1:0] w_base_strb;
    logic [c_WIDE_B-1:0] w_wide_strb;
    logic [c_WIDE_W-1:0] w_wide_mask;
    logic [c_WIDE_W-1:0] w_wide_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_off    = req_addr[c_OFF_W-1:0];
    assign w_nbytes = 4'd1 << req_size;
    assign w_end    = 5'(w_off) + 5'(w_nbytes);
    assign w_cross  = (w_end > 5'(c_BYTES));

    always_comb begin
        w_illegal = (DATA_W == 32) && (req_size == 2'd3);
`ifndef STORE_ALIGNER_MISALIGN_EN
        w_illegal = w_illegal || w_cross;
`endif
    end

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready && !w_illegal;
    // Suppressed under reset so the reset cycle never reports an error.
    assign err       = req_valid && req_ready && w_illegal && !rst;

    // Unshifted strobe: the low n lanes set.
    always_comb begin
        for (int i = 0; i < c_WIDE_B; i++) begin
            w_base_strb[i] = (i < int'(w_nbytes));
        end
    end

    assign w_wide_strb = w_base_strb << w_off;

    for (genvar i = 0; i < c_WIDE_B; i++) begin : g_wide_mask
        assign w_wide_mask[8*i +: 8] = {8{w_wide_strb[i]}};
    end

    // rs2 carries junk above the access size; masking by the strobe keeps
    // unused lanes at zero.
    assign w_wide_data = (c_WIDE_W'(req_data) << {w_off, 3'b000}) & w_wide_mask;

    // ------------------------------------------------------------------
    // Captured beat fields
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
            r_strb <= '0;
        end else if (w_accept) begin
            r_addr <= {req_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
            r_data <= w_wide_data;
            r_strb <= w_wide_strb;
        end
    end

`ifdef STORE_ALIGNER_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cross <= 1'b0;
        end else if (w_accept) begin
            r_cross <= w_cross;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_addr     = '0;
        out_data     = '0;
        out_strb     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_BEAT0;
                end
            end
            S_BEAT0: begin
                out_valid = 1'b1;
                out_addr  = r_addr;
                out_data  = r_data[DATA_W-1:0];
                out_strb  = r_strb[c_BYTES-1:0];
`ifdef STORE_ALIGNER_MISALIGN_EN
                out_last  = !r_cross;
                if (out_ready) begin
                    w_next_state = r_cross ? S_BEAT1 : S_IDLE;
                end
`else
                out_last  = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
`endif
            end
`ifdef STORE_ALIGNER_MISALIGN_EN
            S_BEAT1: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                // Wraps naturally at the top of the address space.
                out_addr  = r_addr + ADDR_W'(c_BYTES);
                out_data  = r_data[c_WIDE_W-1 -: DATA_W];
                out_strb  = r_strb[c_WIDE_B-1 -: c_BYTES];
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < c_BYTES; i++) begin : g_out_mask
        assign out_mask[8*i +: 8] = {8{out_strb[i]}};
    end

endmodule
`default_nettype wire

// File: tb/tb_store_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_aligner
// Purpose  : Self-checking bench for store_aligner (DATA_W=64, ADDR_W=64).
//            A byte-level reference model predicts every beat; directed
//            cases pin known answers, then random traffic with backpressure
//            and occasional resets runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_aligner;

    localparam int DW = 64;
    localparam int AW = 64;
    localparam int NB = DW / 8;
`ifdef STORE_ALIGNER_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr  = '0;
    logic [1:0]    req_size  = '0;
    logic [DW-1:0] req_data  = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic [NB-1:0] out_strb;
    logic [DW-1:0] out_mask;
    logic          out_last;
    logic          err;

    always #5 clk = ~clk;

    store_aligner #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_mask  (out_mask),
        .out_last  (out_last),
        .err       (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a queue of pending beats built byte by byte.
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    function automatic bit req_illegal(input logic [63:0] a, input logic [1:0] s);
        int off;
        int n;
        off = int'(a[2:0]);
        n   = 1 << s;
        return (!MIS_EN) && (off + n > NB);
    endfunction

    function automatic logic [63:0] expand(input logic [7:0] s);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    function automatic void push_req(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
        int          off;
        int          n;
        int          nb;
        int          p;
        logic [63:0] bd [2];
        logic [7:0]  bs [2];
        beat_t       bt;
        off = int'(a[2:0]);
        n   = 1 << s;
        nb  = (off + n > NB) ? 2 : 1;
        bd[0] = '0; bd[1] = '0; bs[0] = '0; bs[1] = '0;
        for (int k = 0; k < n; k++) begin
            p = off + k;
            bd[p / NB][8*(p % NB) +: 8] = d[8*k +: 8];
            bs[p / NB][p % NB]          = 1'b1;
        end
        for (int j = 0; j < nb; j++) begin
            bt.addr = {a[63:3], 3'b000} + 64'(NB * j);
            bt.data = bd[j];
            bt.strb = bs[j];
            bt.last = (j == nb - 1);
            exp_q.push_back(bt);
        end
    endfunction

    logic m_busy;

    // Compare on the falling edge, then advance the model to the state the
    // next rising edge produces from the (now stable) inputs.
    always @(negedge clk) begin
        m_busy = (exp_q.size() != 0);
        chk("out_valid", out_valid, m_busy);
        chk("req_ready", req_ready, !m_busy);
        chk("err", err, req_valid && !m_busy && !rst && req_illegal(req_addr, req_size));
        if (m_busy) begin
            chk("out_addr", out_addr, exp_q[0].addr);
            chk("out_data", out_data, exp_q[0].data);
            chk("out_strb", out_strb, exp_q[0].strb);
            chk("out_mask", out_mask, expand(exp_q[0].strb));
            chk("out_last", out_last, exp_q[0].last);
        end else begin
            chk("idle_addr", out_addr, 64'd0);
            chk("idle_data", out_data, 64'd0);
            chk("idle_strb", out_strb, 64'd0);
            chk("idle_mask", out_mask, 64'd0);
        end
        if (rst) begin
            exp_q.delete();
        end else if (m_busy) begin
            if (out_ready) void'(exp_q.pop_front());
        end else if (req_valid && !req_illegal(req_addr, req_size)) begin
            push_req(req_addr, req_size, req_data);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [63:0] a, input logic [1:0] s, input logic [63:0] d);
        tick();
        req_valid = 1'b1;
        req_addr  = a;
        req_size  = s;
        req_data  = d;
    endtask

    task automatic settle();
        req_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 64'd1);
        chk("rst_valid", out_valid, 64'd0);
        chk("rst_err", err, 64'd0);

        // Aligned byte store; upper rs2 bits must not leak into the beat.
        out_ready = 1'b1;
        drive_req(64'h2003, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB);
        @(negedge clk);
        chk("byte_err", err, 64'd0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("byte_valid", out_valid, 64'd1);
        chk("byte_addr", out_addr, 64'h2000);
        chk("byte_data", out_data, 64'hAB00_0000);
        chk("byte_strb", out_strb, 64'h08);
        chk("byte_mask", out_mask, 64'hFF00_0000);
        chk("byte_last", out_last, 64'd1);
        tick();
        @(negedge clk);
        chk("byte_done", out_valid, 64'd0);
        settle();

`ifdef STORE_ALIGNER_MISALIGN_EN
        // Crossing word store split into two beats.
        drive_req(64'h1006, 2'd2, 64'h1122_3344);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("x_b0_addr", out_addr, 64'h1000);
        chk("x_b0_data", out_data, 64'h3344_0000_0000_0000);
        chk("x_b0_strb", out_strb, 64'hC0);
        chk("x_b0_last", out_last, 64'd0);
        tick();
        @(negedge clk);
        chk("x_b1_addr", out_addr, 64'h1008);
        chk("x_b1_data", out_data, 64'h1122);
        chk("x_b1_strb", out_strb, 64'h03);
        chk("x_b1_last", out_last, 64'd1);
        settle();

        // Backpressure on beat0 for three cycles.
        out_ready = 1'b0;
        drive_req(64'h1006, 2'd2, 64'h1122_3344);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_data", out_data, 64'h3344_0000_0000_0000);
            chk("bp_hold_addr", out_addr, 64'h1000);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_b0_strb", out_strb, 64'hC0);
        tick();
        @(negedge clk);
        chk("bp_b1_addr", out_addr, 64'h1008);
        chk("bp_b1_last", out_last, 64'd1);
        settle();

        // Reset while beat1 is on the bus.
        drive_req(64'h1006, 2'd2, 64'h1122_3344);
        tick();
        req_valid = 1'b0;
        tick();
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rb_b1_valid", out_valid, 64'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rb_valid", out_valid, 64'd0);
        chk("rb_ready", req_ready, 64'd1);
        tick();
        @(negedge clk);
        chk("rb_no_b1", out_valid, 64'd0);
        settle();

        // Double store wrapping past the top of the address space.
        drive_req(64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 64'h0123_4567_89AB_CDEF);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("wrap_b0_addr", out_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("wrap_b0_strb", out_strb, 64'hF0);
        chk("wrap_b0_data", out_data, 64'h89AB_CDEF_0000_0000);
        tick();
        @(negedge clk);
        chk("wrap_b1_addr", out_addr, 64'h0);
        chk("wrap_b1_strb", out_strb, 64'h0F);
        chk("wrap_b1_data", out_data, 64'h0123_4567);
        settle();
`else
        // Crossing word store rejected.
        drive_req(64'h1006, 2'd2, 64'h1122_3344);
        @(negedge clk);
        chk("x_err", err, 64'd1);
        chk("x_valid", out_valid, 64'd0);
        chk("x_ready", req_ready, 64'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("x_err_clear", err, 64'd0);
        chk("x_still_idle", out_valid, 64'd0);
        chk("x_ready2", req_ready, 64'd1);

        // Crossing double store at the top of memory is also rejected.
        drive_req(64'hFFFF_FFFF_FFFF_FFFC, 2'd3, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        chk("wrap_err", err, 64'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("wrap_idle", out_valid, 64'd0);
        settle();

        // Aligned word store in the upper half.
        drive_req(64'h1004, 2'd2, 64'hDEAD_BEEF_1122_3344);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("w_addr", out_addr, 64'h1000);
        chk("w_data", out_data, 64'h1122_3344_0000_0000);
        chk("w_strb", out_strb, 64'hF0);
        settle();
`endif

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            tick();
            req_valid = ($urandom_range(0, 2) != 0);
            req_addr  = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) req_addr[63:3] = '1;
            req_size  = 2'($urandom_range(0, 3));
            req_data  = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        settle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_aligner.md
STORE_ALIGNER -- requirements
Module: store_aligner

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning store data bus width in bits (legal values 32 and 64).
REQ-002 SHALL have parameter ADDR_W, default 64, meaning byte address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: store request present.
REQ-006 SHALL have port req_ready, output, 1 bit: block accepts a request this cycle.
REQ-007 SHALL have port req_addr, input, ADDR_W bits: store byte address.
REQ-008 SHALL have port req_size, input, 2 bits: access size; 0=byte, 1=half, 2=word, 3=double.
REQ-009 SHALL have port req_data, input, DATA_W bits: store data, right-aligned (rs2 value).
REQ-010 SHALL have port out_valid, output, 1 bit: bus beat present.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port out_addr, output, ADDR_W bits: bus-aligned beat address.
REQ-013 SHALL have port out_data, output, DATA_W bits: lane-shifted write data.
REQ-014 SHALL have port out_strb, output, DATA_W/8 bits: byte strobe.
REQ-015 SHALL have port out_mask, output, DATA_W bits: bit mask; each strobe bit expanded to 8 bits.
REQ-016 SHALL have port out_last, output, 1 bit: final beat of the request.
REQ-017 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal request.

Function
REQ-018 Definitions: B=DATA_W/8; off=req_addr mod B; n=2^req_size bytes; cross=(off+n>B).
REQ-019 SHALL have FSM states IDLE, BEAT0, BEAT1; req_ready=1 only in IDLE.
REQ-020 A request SHALL be accepted on req_valid&req_ready. An accepted request SHALL capture the beat fields and move to BEAT0, with out_valid=1 in the next cycle (latency 1).
REQ-021 Beat fields: form the 2*DATA_W-bit value req_data<<(8*off); beat0 data = low half, beat1 data = high half.
REQ-022 Strobes: form the 2*B-bit strobe ((1<<n)-1)<<off; beat0 strb = low B bits, beat1 strb = high B bits.
REQ-023 Addresses: beat0 out_addr = req_addr with low log2(B) bits cleared; beat1 out_addr = beat0 addr + B, wrapping modulo 2^ADDR_W.
REQ-024 Data bits outside strobed lanes SHALL be 0.
REQ-025 BEAT0 transitions on out_ready: to BEAT1 if cross, else to IDLE with out_last=1 during the beat.
REQ-026 BEAT1 SHALL drive out_last=1 and SHALL go to IDLE on out_ready.
REQ-027 All out_* signals SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 A new request SHALL NOT be accepted in the cycle a last beat completes; back-to-back throughput is one request per (beats+1) cycles.
REQ-029 With DATA_W=32, req_size=3 SHALL be illegal: err pulses in the acceptance cycle, no beat is issued, and the FSM stays in IDLE.
REQ-030 out_data, out_strb, out_mask and out_addr SHALL be 0 whenever out_valid=0.

Reset
REQ-031 When rst=1 at a clock edge, the FSM SHALL go to IDLE and out_valid, out_last, err, out_data, out_strb, out_mask and out_addr SHALL be 0.
REQ-032 Reset mid-request, including between beat0 and beat1, SHALL discard the request with no further beats.
REQ-033 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-034 Macro STORE_ALIGNER_MISALIGN_EN defined: crossing requests SHALL split into two beats per REQ-025.
REQ-035 Macro STORE_ALIGNER_MISALIGN_EN undefined: a crossing request SHALL be illegal and handled as in REQ-029 (err pulse, no beat); BEAT1 state logic SHALL be absent.

Verification (DATA_W=64)
REQ-036 Aligned byte store: addr 0x2003, size 0, data 0xAB -> one beat with addr 0x2000, data 0xAB000000, strb 0x08, mask 0xFF000000, last=1.
REQ-037 Crossing word store, macro on: addr 0x1006, size 2, data 0x11223344 -> beat0 addr 0x1000, data 0x3344000000000000, strb 0xC0, last=0; then beat1 addr 0x1008, data 0x1122, strb 0x03, last=1.
REQ-038 Same stimulus as REQ-037 with the macro off -> err=1 for one cycle, out_valid stays 0, req_ready stays 1.
REQ-039 Backpressure: hold out_ready=0 for 3 cycles during beat0 of REQ-037 -> outputs stable, then both beats delivered in order.
REQ-040 Reset between beats: assert rst in the BEAT1 cycle of REQ-037 -> next cycle out_valid=0, req_ready=1, no beat1 observed.
REQ-041 Address wrap: addr 0xFFFFFFFFFFFFFFFC, size 3 -> beat0 strb 0xF0, beat1 addr 0x0, strb 0x0F.
